pixel_ram_arbiter: RTL and testbench

Shares one 16K x 16 SB_SPRAM256KA pixel frame buffer between two requesters. The first is the LED-matrix scan engine's pixel reader (display port), which has priority. The second is the Wishbone bus slave used by the CPU to draw frames. The block replaces ad-hoc mem_busy muxing and guarantees registered, glitch-free Wishbone acks with bounded CPU wait. It sits between the led-matrix scan logic, the Wishbone interconnect and the SPRAM primitive, which is instantiated in the parent.

---
 rtl/pixel_ram_arbiter_pkg.sv | 20 ++
 rtl/pixel_ram_arbiter.sv | 127 ++++++++++++
 tb/tb_pixel_ram_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_ram_arbiter_pkg.sv
// Shared definitions for the pixel frame-buffer arbiter: one-hot state
// encoding, the default frame-buffer window base, and the byte-select to
// SPRAM nibble-mask expansion.
package pixel_ram_arbiter_pkg;

  // One-hot arbiter states; ack_o is decoded straight from the WB_ACK flop.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b01,
    ARB_WB_ACK = 2'b10
  } arb_state_t;

  // Default Wishbone window for the frame buffer (16K words at 0x4000).
  localparam logic [15:0] DEFAULT_FB_BASE = 16'h4000;

  // SPRAM write masks are per nibble, so each byte select covers two bits.
  function automatic logic [3:0] sel_to_maskwren(input logic [1:0] sel);
    return {sel[1], sel[1], sel[0], sel[0]};
  endfunction

endpackage

// File: rtl/pixel_ram_arbiter.sv
// Arbitrates one SPRAM frame buffer between the LED-matrix scan reader
// (priority, one access per cycle) and the Wishbone CPU port. The CPU is
// guaranteed a slot after at most STARVE_LIMIT consecutive display grants,
// and its ack is a single registered pulse one cycle after the RAM access.
module pixel_ram_arbiter
  import pixel_ram_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int DATA_BYTES     = 2,
  parameter int MEM_ADDR_WIDTH = 14,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS = DEFAULT_FB_BASE,
  parameter int STARVE_LIMIT   = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [ADDRESS_WIDTH-1:0]  adr_i,
  input  logic [DATA_WIDTH-1:0]     dat_i,
  output logic [DATA_WIDTH-1:0]     dat_o,
  input  logic                      we_i,
  input  logic [DATA_BYTES-1:0]     sel_i,
  input  logic                      stb_i,
  input  logic                      cyc_i,
  output logic                      ack_o,
  input  logic                      disp_req_i,
  input  logic [MEM_ADDR_WIDTH-1:0] disp_addr_i,
  output logic                      disp_gnt_o,
  output logic                      disp_valid_o,
  output logic [15:0]               disp_data_o,
  output logic [MEM_ADDR_WIDTH-1:0] ram_addr_o,
  output logic [15:0]               ram_data_o,
  output logic [3:0]                ram_maskwren_o,
  output logic                      ram_wren_o,
  input  logic [15:0]               ram_data_i
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t                state_q, state_d;
  logic [CNT_W-1:0]          starve_cnt_q, starve_cnt_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic                      we_q;
  logic                      wb_hit;
  logic                      wb_pend;
  logic                      wb_win;
  logic                      disp_win;

  // Only accesses inside the frame-buffer window are ever serviced.
  assign wb_hit  = cyc_i & stb_i &
                   (adr_i[ADDRESS_WIDTH-1:MEM_ADDR_WIDTH] ==
                    BASE_ADDRESS[ADDRESS_WIDTH-1:MEM_ADDR_WIDTH]);
  assign wb_pend = wb_hit;

  // Pick the owner of this cycle's RAM slot and track display-induced starvation.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    wb_win       = 1'b0;
    disp_win     = 1'b0;
    if (!rst_i) begin
      case (state_q)
        ARB_IDLE: begin
          if (wb_pend && (!disp_req_i || starve_cnt_q == STARVE_MAX)) begin
            wb_win       = 1'b1;
            state_d      = ARB_WB_ACK;
            starve_cnt_d = '0;
          end else begin
            disp_win = disp_req_i;
            if (!wb_pend) begin
              starve_cnt_d = '0;
            end else if (disp_req_i && starve_cnt_q != STARVE_MAX) begin
              starve_cnt_d = starve_cnt_q + 1'b1;
            end
          end
        end
        ARB_WB_ACK: begin
          disp_win = disp_req_i;
          state_d  = ARB_IDLE;
        end
        default: begin
          state_d = ARB_IDLE;
        end
      endcase
    end
  end

  // Drive the SPRAM port from whichever side won; an idle slot keeps the last address.
  always_comb begin
    ram_addr_o     = addr_q;
    ram_maskwren_o = 4'b0000;
    ram_wren_o     = 1'b0;
    ram_data_o     = dat_i;
    if (wb_win) begin
      ram_addr_o     = adr_i[MEM_ADDR_WIDTH-1:0];
      ram_maskwren_o = sel_to_maskwren(sel_i);
      ram_wren_o     = we_i & (|sel_i);
    end else if (disp_win) begin
      ram_addr_o = disp_addr_i;
    end
  end

  assign disp_gnt_o  = disp_win;
  assign ack_o       = (state_q == ARB_WB_ACK);
  assign dat_o       = (ack_o && !we_q) ? ram_data_i : '0;
  assign disp_data_o = disp_valid_o ? ram_data_i : 16'h0000;

  // State, starvation counter, held address and per-transaction flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ARB_IDLE;
      starve_cnt_q <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      disp_valid_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= ram_addr_o;
      disp_valid_o <= disp_gnt_o;
      if (wb_win) begin
        we_q <= we_i;
      end
    end
  end

endmodule

// File: tb/tb_pixel_ram_arbiter.sv
// Testbench for pixel_ram_arbiter: a behavioural SPRAM sits on the RAM port,
// and Wishbone read data and display read data are checked against queues of
// expected words derived from the bench's own record of what was written.
module tb_pixel_ram_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [15:0] adr_i = '0;
  logic [15:0] dat_i = '0;
  logic [15:0] dat_o;
  logic        we_i = 1'b0;
  logic [1:0]  sel_i = '0;
  logic        stb_i = 1'b0;
  logic        cyc_i = 1'b0;
  logic        ack_o;
  logic        disp_req_i = 1'b0;
  logic [13:0] disp_addr_i = '0;
  logic        disp_gnt_o;
  logic        disp_valid_o;
  logic [15:0] disp_data_o;
  logic [13:0] ram_addr_o;
  logic [15:0] ram_data_o;
  logic [3:0]  ram_maskwren_o;
  logic        ram_wren_o;
  logic [15:0] ram_data_i = '0;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] wb_exp_q[$];
  logic [15:0] disp_exp_q[$];
  logic [15:0] ref_mem[int];

  logic [15:0] ram_mem [0:16383];
  bit          ram_written [0:16383];

  pixel_ram_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .we_i(we_i), .sel_i(sel_i), .stb_i(stb_i), .cyc_i(cyc_i), .ack_o(ack_o),
    .disp_req_i(disp_req_i), .disp_addr_i(disp_addr_i), .disp_gnt_o(disp_gnt_o),
    .disp_valid_o(disp_valid_o), .disp_data_o(disp_data_o),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
    .ram_maskwren_o(ram_maskwren_o), .ram_wren_o(ram_wren_o),
    .ram_data_i(ram_data_i)
  );

  always #5 clk_i = ~clk_i;

  // Preloaded frame-buffer contents for words never written.
  function automatic logic [15:0] init_word(input int a);
    logic [15:0] w;
    w = 16'(a) * 16'h0107;
    return w ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] ram_cur(input logic [13:0] a);
    return ram_written[a] ? ram_mem[a] : init_word(int'(a));
  endfunction

  function automatic logic [15:0] nibble_merge(input logic [15:0] old_w,
                                               input logic [15:0] new_w,
                                               input logic [3:0] m);
    logic [15:0] r;
    r = old_w;
    for (int n = 0; n < 4; n++) if (m[n]) r[n*4 +: 4] = new_w[n*4 +: 4];
    return r;
  endfunction

  function automatic logic [15:0] ref_read(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [15:0] byte_merge(input logic [15:0] old_w,
                                             input logic [15:0] new_w,
                                             input logic [1:0] sel);
    logic [15:0] r;
    r = old_w;
    if (sel[0]) r[7:0]  = new_w[7:0];
    if (sel[1]) r[15:8] = new_w[15:8];
    return r;
  endfunction

  // Behavioural SPRAM: nibble-masked writes, one-cycle registered read.
  always @(posedge clk_i) begin
    if (ram_wren_o) begin
      ram_mem[ram_addr_o]     <= nibble_merge(ram_cur(ram_addr_o), ram_data_o, ram_maskwren_o);
      ram_written[ram_addr_o] <= 1'b1;
    end else begin
      ram_data_i <= ram_cur(ram_addr_o);
    end
  end

  // Issue one Wishbone cycle and wait (bounded) for ack.
  task automatic wb_transfer(input logic [15:0] adr, input logic [15:0] dat,
                             input logic we, input logic [1:0] sel, input int limit,
                             output logic acked, output logic [15:0] rdata,
                             output int lat, output logic saw_wren,
                             output logic [3:0] mask_seen, output logic [13:0] addr_seen);
    acked = 1'b0; rdata = '0; lat = 0; saw_wren = 1'b0; mask_seen = '0; addr_seen = '0;
    @(negedge clk_i);
    cyc_i = 1'b1; stb_i = 1'b1; adr_i = adr; dat_i = dat; we_i = we; sel_i = sel;
    while (!acked && lat < limit) begin
      #1;
      lat++;
      if (lat == 1 || ram_wren_o) begin
        addr_seen = ram_addr_o;
        mask_seen = ram_maskwren_o;
      end
      if (ram_wren_o) saw_wren = 1'b1;
      if (ack_o) begin
        acked = 1'b1;
        rdata = dat_o;
      end else begin
        @(negedge clk_i);
      end
    end
    @(negedge clk_i);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    disp_req_i = 1'b1; disp_addr_i = 14'h0123;
    cyc_i = 1'b1; stb_i = 1'b1; adr_i = 16'h4005; we_i = 1'b1; sel_i = 2'b11; dat_i = 16'h7777;
    repeat (2) @(negedge clk_i);
    #1;
    vectors++; if (ack_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ack: got %b want 0", ack_o); end
    vectors++; if (disp_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b want 0", disp_valid_o); end
    vectors++; if (disp_data_o !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_disp_data: got %h want 0000", disp_data_o); end
    vectors++; if (dat_o !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_dat: got %h want 0000", dat_o); end
    vectors++; if (ram_wren_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wren: got %b want 0", ram_wren_o); end
    vectors++; if (ram_addr_o !== 14'h0) begin miscompares++; $display("[TB] FAIL reset_addr: got %h want 0000", ram_addr_o); end
    vectors++; if (disp_gnt_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_gnt: got %b want 0", disp_gnt_o); end
    @(negedge clk_i);
    rst_i = 1'b0; disp_req_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(negedge clk_i); #1;
    vectors++; if (ack_o !== 1'b0) begin miscompares++; $display("[TB] FAIL post_reset_ack: got %b want 0", ack_o); end
    vectors++; if (disp_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL post_reset_valid: got %b want 0", disp_valid_o); end
  endtask

  task automatic test_write_read();
    logic acked, saw_wren; logic [15:0] rdata; int lat; logic [3:0] m; logic [13:0] a;
    logic [15:0] exp_w;
    ref_mem[5] = 16'hA5C3;
    wb_transfer(16'h4005, 16'hA5C3, 1'b1, 2'b11, 20, acked, rdata, lat, saw_wren, m, a);
    vectors++; if (acked !== 1'b1 || lat != 2) begin miscompares++; $display("[TB] FAIL wr_ack_latency: got ack=%b lat=%0d want ack=1 lat=2", acked, lat); end
    vectors++; if (saw_wren !== 1'b1 || a !== 14'h0005) begin miscompares++; $display("[TB] FAIL wr_ram_access: got wren=%b addr=%h want wren=1 addr=0005", saw_wren, a); end
    vectors++; if (m !== 4'b1111) begin miscompares++; $display("[TB] FAIL wr_mask: got %b want 1111", m); end
    vectors++; if (ack_o !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_ack_single: got %b want 0", ack_o); end
    wb_exp_q.push_back(ref_read(5));
    wb_transfer(16'h4005, 16'h0000, 1'b0, 2'b11, 20, acked, rdata, lat, saw_wren, m, a);
    vectors++; if (acked !== 1'b1 || lat != 2) begin miscompares++; $display("[TB] FAIL rd_ack_latency: got ack=%b lat=%0d want ack=1 lat=2", acked, lat); end
    vectors++; if (saw_wren !== 1'b0 || a !== 14'h0005) begin miscompares++; $display("[TB] FAIL rd_ram_access: got wren=%b addr=%h want wren=0 addr=0005", saw_wren, a); end
    if (acked && wb_exp_q.size() > 0) begin
      exp_w = wb_exp_q.pop_front();
      vectors++; if (rdata !== exp_w) begin miscompares++; $display("[TB] FAIL rd_data: got %h want %h", rdata, exp_w); end
    end
    vectors++; if (dat_o !== 16'h0) begin miscompares++; $display("[TB] FAIL rd_dat_after_ack: got %h want 0000", dat_o); end
  endtask

  task automatic test_byte_write();
    logic acked, saw_wren; logic [15:0] rdata; int lat; logic [3:0] m; logic [13:0] a;
    logic [15:0] exp_w;
    wb_transfer(16'h4010, 16'h1234, 1'b1, 2'b11, 20, acked, rdata, lat, saw_wren, m, a);
    ref_mem[16] = 16'h1234;
    wb_transfer(16'h4010, 16'hFFFF, 1'b1, 2'b01, 20, acked, rdata, lat, saw_wren, m, a);
    ref_mem[16] = byte_merge(ref_read(16), 16'hFFFF, 2'b01);
    vectors++; if (m !== 4'b0011 || saw_wren !== 1'b1) begin miscompares++; $display("[TB] FAIL byte_mask: got mask=%b wren=%b want 0011/1", m, saw_wren); end
    wb_transfer(16'h4010, 16'h0000, 1'b1, 2'b00, 20, acked, rdata, lat, saw_wren, m, a);
    vectors++; if (acked !== 1'b1 || saw_wren !== 1'b0) begin miscompares++; $display("[TB] FAIL nosel_write: got ack=%b wren=%b want ack=1 wren=0", acked, saw_wren); end
    wb_exp_q.push_back(ref_read(16));
    wb_transfer(16'h4010, 16'h0000, 1'b0, 2'b11, 20, acked, rdata, lat, saw_wren, m, a);
    vectors++; if (acked !== 1'b1) begin miscompares++; $display("[TB] FAIL byte_rd_ack: got %b want 1", acked); end
    if (acked && wb_exp_q.size() > 0) begin
      exp_w = wb_exp_q.pop_front();
      vectors++; if (rdata !== exp_w) begin miscompares++; $display("[TB] FAIL byte_rd_data: got %h want %h", rdata, exp_w); end
    end
  endtask

  task automatic test_display_stream();
    logic prev_gnt; logic [15:0] exp_w;
    prev_gnt = 1'b0;
    disp_exp_q.delete();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk_i);
      disp_req_i  = (i < 12);
      disp_addr_i = 14'(100 + i);
      #1;
      if (i < 12) begin
        vectors++; if (disp_gnt_o !== 1'b1 || ram_addr_o !== 14'(100 + i)) begin miscompares++; $display("[TB] FAIL stream_gnt[%0d]: got gnt=%b addr=%h want 1/%h", i, disp_gnt_o, ram_addr_o, 14'(100 + i)); end
      end
      vectors++; if (disp_valid_o !== prev_gnt) begin miscompares++; $display("[TB] FAIL stream_valid[%0d]: got %b want %b", i, disp_valid_o, prev_gnt); end
      if (disp_valid_o && disp_exp_q.size() > 0) begin
        exp_w = disp_exp_q.pop_front();
        vectors++; if (disp_data_o !== exp_w) begin miscompares++; $display("[TB] FAIL stream_data[%0d]: got %h want %h", i, disp_data_o, exp_w); end
      end
      if (disp_gnt_o) disp_exp_q.push_back(ref_read(100 + i));
      prev_gnt = disp_gnt_o;
    end
    vectors++; if (disp_exp_q.size() != 0) begin miscompares++; $display("[TB] FAIL stream_drain: got %0d left want 0", disp_exp_q.size()); end
  endtask

  task automatic test_starvation();
    logic prev_gnt; logic [15:0] exp_w;
    int grants, grant_cycle, ack_cycle, acks;
    prev_gnt = 1'b0; grants = 0; grant_cycle = 0; ack_cycle = 0; acks = 0;
    disp_exp_q.delete();
    wb_exp_q.push_back(ref_read(5));
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk_i);
      disp_req_i  = (ack_cycle == 0 || c <= ack_cycle + 3);
      disp_addr_i = 14'(200 + c);
      if (c == 1) begin
        cyc_i = 1'b1; stb_i = 1'b1; adr_i = 16'h4005; we_i = 1'b0; sel_i = 2'b11;
      end
      if (ack_cycle != 0 && c == ack_cycle + 1) begin
        cyc_i = 1'b0; stb_i = 1'b0;
      end
      #1;
      if (grant_cycle == 0) begin
        if (disp_gnt_o) grants++;
        else if (disp_req_i) begin
          grant_cycle = c;
          vectors++; if (ram_addr_o !== 14'h0005 || ram_wren_o !== 1'b0) begin miscompares++; $display("[TB] FAIL starve_wb_slot: got addr=%h wren=%b want 0005/0", ram_addr_o, ram_wren_o); end
        end
      end
      if (ack_o) begin
        acks++;
        if (ack_cycle == 0) begin
          ack_cycle = c;
          vectors++; if (disp_gnt_o !== 1'b1) begin miscompares++; $display("[TB] FAIL starve_gnt_in_ack: got %b want 1", disp_gnt_o); end
          if (wb_exp_q.size() > 0) begin
            exp_w = wb_exp_q.pop_front();
            vectors++; if (dat_o !== exp_w) begin miscompares++; $display("[TB] FAIL starve_rd_data: got %h want %h", dat_o, exp_w); end
          end
        end
      end
      if (ack_cycle != 0 && (c == ack_cycle + 1 || c == ack_cycle + 2)) begin
        vectors++; if (disp_gnt_o !== 1'b1) begin miscompares++; $display("[TB] FAIL starve_resume[%0d]: got %b want 1", c, disp_gnt_o); end
      end
      vectors++; if (disp_valid_o !== prev_gnt) begin miscompares++; $display("[TB] FAIL starve_valid[%0d]: got %b want %b", c, disp_valid_o, prev_gnt); end
      if (disp_valid_o && disp_exp_q.size() > 0) begin
        exp_w = disp_exp_q.pop_front();
        vectors++; if (disp_data_o !== exp_w) begin miscompares++; $display("[TB] FAIL starve_disp_data[%0d]: got %h want %h", c, disp_data_o, exp_w); end
      end
      if (disp_gnt_o) disp_exp_q.push_back(ref_read(200 + c));
      prev_gnt = disp_gnt_o;
      if (ack_cycle != 0 && c >= ack_cycle + 5) break;
    end
    cyc_i = 1'b0; stb_i = 1'b0; disp_req_i = 1'b0;
    vectors++; if (grants != 8 || grant_cycle != 9) begin miscompares++; $display("[TB] FAIL starve_grants: got grants=%0d wb_slot=%0d want 8/9", grants, grant_cycle); end
    vectors++; if (ack_cycle != 10 || acks != 1) begin miscompares++; $display("[TB] FAIL starve_ack: got cycle=%0d count=%0d want 10/1", ack_cycle, acks); end
    vectors++; if (disp_exp_q.size() != 0) begin miscompares++; $display("[TB] FAIL starve_drain: got %0d left want 0", disp_exp_q.size()); end
  endtask

  task automatic test_drop_before_grant();
    int grant_cycle, early_acks;
    grant_cycle = 0; early_acks = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk_i);
      disp_req_i = 1'b1; disp_addr_i = 14'(300 + c);
      cyc_i = (c <= 3 || c >= 6); stb_i = cyc_i;
      adr_i = 16'h4005; we_i = 1'b0; sel_i = 2'b11;
      #1;
      if (ack_o && grant_cycle == 0) early_acks++;
      if (!disp_gnt_o && grant_cycle == 0) grant_cycle = c;
      if (grant_cycle != 0) break;
    end
    @(negedge clk_i);
    #1;
    vectors++; if (ack_o !== 1'b1) begin miscompares++; $display("[TB] FAIL drop_ack: got %b want 1", ack_o); end
    @(negedge clk_i);
    cyc_i = 1'b0; stb_i = 1'b0; disp_req_i = 1'b0;
    vectors++; if (grant_cycle != 14 || early_acks != 0) begin miscompares++; $display("[TB] FAIL drop_starve_clear: got slot=%0d early_acks=%0d want 14/0", grant_cycle, early_acks); end
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_miss();
    logic acked, saw_wren; logic [15:0] rdata; int lat; logic [3:0] m; logic [13:0] a;
    wb_transfer(16'h8000, 16'hDEAD, 1'b1, 2'b11, 20, acked, rdata, lat, saw_wren, m, a);
    vectors++; if (acked !== 1'b0) begin miscompares++; $display("[TB] FAIL miss_ack: got %b want 0", acked); end
    vectors++; if (saw_wren !== 1'b0) begin miscompares++; $display("[TB] FAIL miss_wren: got %b want 0", saw_wren); end
  endtask

  task automatic test_reset_mid_write();
    logic acked, saw_wren; logic [15:0] rdata; int lat; logic [3:0] m; logic [13:0] a;
    int acks; logic [15:0] exp_w;
    acks = 0;
    @(negedge clk_i);
    cyc_i = 1'b1; stb_i = 1'b1; adr_i = 16'h4020; dat_i = 16'hBEEF; we_i = 1'b1; sel_i = 2'b11;
    #1;
    vectors++; if (ram_wren_o !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_mid_grant: got %b want 1", ram_wren_o); end
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (ack_o) acks++;
      @(negedge clk_i);
    end
    vectors++; if (acks != 0) begin miscompares++; $display("[TB] FAIL rst_mid_ack: got %0d pulses want 0", acks); end
    wb_transfer(16'h4020, 16'hBEEF, 1'b1, 2'b11, 20, acked, rdata, lat, saw_wren, m, a);
    ref_mem[32] = 16'hBEEF;
    vectors++; if (acked !== 1'b1 || lat != 2) begin miscompares++; $display("[TB] FAIL rst_retry_write: got ack=%b lat=%0d want 1/2", acked, lat); end
    wb_exp_q.push_back(ref_read(32));
    wb_transfer(16'h4020, 16'h0000, 1'b0, 2'b11, 20, acked, rdata, lat, saw_wren, m, a);
    vectors++; if (acked !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_retry_rd_ack: got %b want 1", acked); end
    if (acked && wb_exp_q.size() > 0) begin
      exp_w = wb_exp_q.pop_front();
      vectors++; if (rdata !== exp_w) begin miscompares++; $display("[TB] FAIL rst_retry_rd_data: got %h want %h", rdata, exp_w); end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] starting pixel_ram_arbiter bench");
    test_reset();
    test_write_read();
    test_byte_write();
    test_display_stream();
    test_starvation();
    test_drop_before_grant();
    test_miss();
    test_reset_mid_write();
    vectors++; if (wb_exp_q.size() != 0) begin miscompares++; $display("[TB] FAIL wb_queue_drain: got %0d left want 0", wb_exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
